// File: rtl/quick_spi_pkg.sv
// Shared op encodings and sequencer FSM states for the quick_spi command front-end.
// Pure declarations: no latency, no backpressure.
package quick_spi_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LAUNCH   = 2'd1,
    ST_WAIT_EOT = 2'd2,
    ST_GAP      = 2'd3
  } seq_state_t;

endpackage

// File: rtl/quick_spi_sync_fifo.sv
// Synchronous FIFO, power-of-2 DEPTH; read data is the registered head (no bypass), 0-cycle read latency.
// Pushes while full and pops while empty are ignored; full/empty/count derive from the registered count.
module quick_spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_pop_dat = r_mem[r_rd_ptr];
  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

endmodule

// File: rtl/quick_spi_sequencer.sv
// Queues host commands and runs them one at a time on quick_spi; start 1 cycle after a head is seen in IDLE.
// cmd_ready = cmd FIFO not full; reads wait for rsp space. Watchdog only with QUICK_SPI_SEQ_TIMEOUT_EN.
import quick_spi_pkg::*;

module quick_spi_sequencer #(
  parameter int NUMBER_OF_SLAVES    = 2,
  parameter int OUTGOING_DATA_WIDTH = 16,
  parameter int INCOMING_DATA_WIDTH = 8,
  parameter int CMD_FIFO_DEPTH      = 4,
  parameter int RSP_FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES      = 1024
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [NUMBER_OF_SLAVES-1:0]    cmd_slave,
  input  logic                           cmd_operation,
  input  logic [OUTGOING_DATA_WIDTH-1:0] cmd_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [INCOMING_DATA_WIDTH-1:0] rsp_data,
  output logic [NUMBER_OF_SLAVES-1:0]    rsp_slave,
  output logic                           start_transaction,
  output logic [NUMBER_OF_SLAVES-1:0]    slave,
  output logic                           operation,
  output logic [OUTGOING_DATA_WIDTH-1:0] outgoing_data,
  input  logic                           end_of_transaction,
  input  logic [INCOMING_DATA_WIDTH-1:0] incoming_data,
  output logic                           busy,
  output logic                           timeout_error
);

  localparam int CMD_W = 1 + NUMBER_OF_SLAVES + OUTGOING_DATA_WIDTH;
  localparam int RSP_W = NUMBER_OF_SLAVES + INCOMING_DATA_WIDTH;
  localparam int RCW   = $clog2(RSP_FIFO_DEPTH) + 1;
  localparam logic [RCW-1:0] RSP_FULL_CNT = RCW'(RSP_FIFO_DEPTH);

  seq_state_t                     r_state;
  logic                           r_start;
  logic [NUMBER_OF_SLAVES-1:0]    r_slave;
  logic                           r_operation;
  logic [OUTGOING_DATA_WIDTH-1:0] r_outgoing_data;

  logic                           w_cmd_push;
  logic                           w_cmd_full;
  logic                           w_cmd_empty;
  logic [CMD_W-1:0]               w_cmd_head;
  logic                           w_head_op;
  logic [NUMBER_OF_SLAVES-1:0]    w_head_slave;
  logic [OUTGOING_DATA_WIDTH-1:0] w_head_data;
  logic                           w_rsp_empty;
  logic [RCW-1:0]                 w_rsp_count;
  logic [RSP_W-1:0]               w_rsp_head;
  logic                           w_rsp_space;
  logic                           w_launch;
  logic                           w_rsp_push;
  logic                           w_timeout;

  assign w_cmd_push = cmd_valid && cmd_ready;
  assign cmd_ready  = !w_cmd_full;

  quick_spi_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_cmd_push),
    .i_push_dat ({cmd_operation, cmd_slave, cmd_data}),
    .i_pop      (w_launch),
    .o_pop_dat  (w_cmd_head),
    .o_full     (w_cmd_full),
    .o_empty    (w_cmd_empty),
    .o_count    ()
  );

  assign {w_head_op, w_head_slave, w_head_data} = w_cmd_head;

  // Only one transfer is ever outstanding and IDLE is reached after its response was pushed,
  // so the live count already covers reads in flight when the launch decision is made.
  assign w_rsp_space = (w_rsp_count < RSP_FULL_CNT);
  assign w_launch    = (r_state == ST_IDLE) && !w_cmd_empty &&
                       ((w_head_op == OP_WRITE) || w_rsp_space);
  assign w_rsp_push  = (r_state == ST_WAIT_EOT) && end_of_transaction &&
                       (r_operation == OP_READ);

  quick_spi_sync_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_rsp_push),
    .i_push_dat ({r_slave, incoming_data}),
    .i_pop      (rsp_ready),
    .o_pop_dat  (w_rsp_head),
    .o_full     (),
    .o_empty    (w_rsp_empty),
    .o_count    (w_rsp_count)
  );

  assign rsp_valid              = !w_rsp_empty;
  assign {rsp_slave, rsp_data}  = w_rsp_head;

`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_timer;
  logic          r_timeout_error;

  assign w_timeout = (r_state == ST_WAIT_EOT) && !end_of_transaction && (r_timer == TIMER_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer         <= '0;
      r_timeout_error <= 1'b0;
    end else begin
      if (r_state == ST_LAUNCH)
        r_timer <= '0;
      else if (r_state == ST_WAIT_EOT && !w_timeout)
        r_timer <= r_timer + 1'b1;
      if (w_timeout)
        r_timeout_error <= 1'b1;
    end
  end

  assign timeout_error = r_timeout_error;
`else
  assign w_timeout     = 1'b0;
  assign timeout_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_start         <= 1'b0;
      r_slave         <= '0;
      r_operation     <= 1'b0;
      r_outgoing_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_slave         <= w_head_slave;
            r_operation     <= w_head_op;
            r_outgoing_data <= w_head_data;
            r_start         <= 1'b1;
            r_state         <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_start <= 1'b0;
          r_state <= ST_WAIT_EOT;
        end
        ST_WAIT_EOT: begin
          if (end_of_transaction || w_timeout)
            r_state <= ST_GAP;
        end
        ST_GAP:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign start_transaction = r_start;
  assign slave             = r_slave;
  assign operation         = r_operation;
  assign outgoing_data     = r_outgoing_data;
  assign busy              = (r_state != ST_IDLE) || !w_cmd_empty;

endmodule

// File: tb/tb_quick_spi_sequencer.sv
// Bench for quick_spi_sequencer with a behavioural SPI endpoint that answers each read with the low byte of its word.
`timescale 1ns/1ps
import quick_spi_pkg::*;

module tb_quick_spi_sequencer;
  localparam int NS = 2;
  localparam int OW = 16;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_operation;
  logic [NS-1:0] cmd_slave;
  logic [OW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready;
  logic [IW-1:0] rsp_data;
  logic [NS-1:0] rsp_slave;
  logic          start_transaction, operation, end_of_transaction, busy, timeout_error;
  logic [NS-1:0] slave;
  logic [OW-1:0] outgoing_data;
  logic [IW-1:0] incoming_data;

  always #5 clk = ~clk;

  quick_spi_sequencer #(
    .NUMBER_OF_SLAVES(NS), .OUTGOING_DATA_WIDTH(OW), .INCOMING_DATA_WIDTH(IW),
    .CMD_FIFO_DEPTH(4), .RSP_FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_slave(cmd_slave),
    .cmd_operation(cmd_operation), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_slave(rsp_slave),
    .start_transaction(start_transaction), .slave(slave), .operation(operation),
    .outgoing_data(outgoing_data), .end_of_transaction(end_of_transaction),
    .incoming_data(incoming_data), .busy(busy), .timeout_error(timeout_error)
  );

  typedef struct packed {
    logic          op;
    logic [NS-1:0] sl;
    logic [OW-1:0] d;
  } cmd_t;

  typedef struct {
    logic          op;
    logic [NS-1:0] sl;
    logic [OW-1:0] d;
    logic [IW-1:0] rsp;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  cmd_t launch_q[$];
  int   launch_cnt = 0;
  logic model_en = 1'b1;
  int   model_lat = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every start pulse is logged so the order of issued commands can be checked afterwards.
  initial forever begin
    @(negedge clk);
    if (reset_n && start_transaction) begin
      launch_q.push_back({operation, slave, outgoing_data});
      launch_cnt++;
    end
  end

  initial begin
    cmd_t m_held;
    logic m_moved;
    int   m_lat;
    end_of_transaction = 1'b0;
    incoming_data      = '0;
    forever begin
      @(negedge clk);
      if (model_en && reset_n && start_transaction) begin
        m_held  = {operation, slave, outgoing_data};
        m_moved = 1'b0;
        m_lat   = model_lat;
        for (int k = 0; k < m_lat; k++) begin
          @(negedge clk);
          if ({operation, slave, outgoing_data} !== m_held) m_moved = 1'b1;
        end
        end_of_transaction = 1'b1;
        incoming_data      = m_held.d[IW-1:0];
        @(negedge clk);
        end_of_transaction = 1'b0;
        incoming_data      = '0;
        check("hold_during_xfer", {31'd0, m_moved}, 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge, so calls chain back-to-back.
  task automatic push(input logic op, input logic [NS-1:0] sl, input logic [OW-1:0] d);
    int t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("push_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    if (cmd_ready) begin
      cmd_valid = 1'b1; cmd_operation = op; cmd_slave = sl; cmd_data = d;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic pop_expect(input string name, input logic [IW-1:0] d, input logic [NS-1:0] sl);
    int t = 0;
    while (!rsp_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({name, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    if (rsp_valid) begin
      check({name, "_rsp_data"}, {24'd0, rsp_data}, {24'd0, d});
      check({name, "_rsp_slave"}, {30'd0, rsp_slave}, {30'd0, sl});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((busy || end_of_transaction) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic expect_launch(input string name, input cmd_t exp);
    if (launch_q.size() == 0) begin
      check({name, "_launch_present"}, 32'd0, 32'd1);
    end else begin
      check(name, {13'd0, launch_q.pop_front()}, {13'd0, exp});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   base;
    int   cnt;

    vt[0] = '{OP_WRITE, 2'd1, 16'hA55A, 8'h00};
    vt[1] = '{OP_READ,  2'd0, 16'h003C, 8'h3C};
    vt[2] = '{OP_READ,  2'd1, 16'h1281, 8'h81};
    vt[3] = '{OP_WRITE, 2'd0, 16'hBEEF, 8'h00};
    vt[4] = '{OP_READ,  2'd3, 16'h77F0, 8'hF0};
    vt[5] = '{OP_WRITE, 2'd2, 16'h0001, 8'h00};

    cmd_valid = 1'b0; cmd_operation = 1'b0; cmd_slave = '0; cmd_data = '0; rsp_ready = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start", {31'd0, start_transaction}, 32'd0);
    check("rst_slave", {30'd0, slave}, 32'd0);
    check("rst_operation", {31'd0, operation}, 32'd0);
    check("rst_outgoing_data", {16'd0, outgoing_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_timeout_error", {31'd0, timeout_error}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single commands, one at a time, with varying endpoint latency.
    for (int i = 0; i < 6; i++) begin
      base      = launch_cnt;
      model_lat = 1 + i;
      push(vt[i].op, vt[i].sl, vt[i].d);
      wait_idle("vec");
      check("vec_launch_count", launch_cnt - base, 32'd1);
      expect_launch("vec_launch", {vt[i].op, vt[i].sl, vt[i].d});
      if (vt[i].op == OP_READ) pop_expect("vec", vt[i].rsp, vt[i].sl);
      check("vec_rsp_empty", {31'd0, rsp_valid}, 32'd0);
    end

    // Stray end_of_transaction while idle must not push a response.
    end_of_transaction = 1'b1; incoming_data = 8'h55;
    @(negedge clk);
    end_of_transaction = 1'b0; incoming_data = 8'h00;
    @(negedge clk);
    check("stray_eot_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("stray_eot_start", {31'd0, start_transaction}, 32'd0);

    // A long write stalls the FSM so four queued commands fill the FIFO.
    launch_q.delete();
    model_lat = 30;
    push(OP_WRITE, 2'd2, 16'h1111);
    repeat (3) @(negedge clk);
    model_lat = 3;
    push(OP_READ,  2'd1, 16'h0042);
    push(OP_WRITE, 2'd0, 16'h2222);
    push(OP_READ,  2'd3, 16'h0099);
    push(OP_WRITE, 2'd1, 16'h3333);
    check("fill_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    wait_idle("fill");
    expect_launch("fill_l0", {OP_WRITE, 2'd2, 16'h1111});
    expect_launch("fill_l1", {OP_READ,  2'd1, 16'h0042});
    expect_launch("fill_l2", {OP_WRITE, 2'd0, 16'h2222});
    expect_launch("fill_l3", {OP_READ,  2'd3, 16'h0099});
    expect_launch("fill_l4", {OP_WRITE, 2'd1, 16'h3333});
    pop_expect("fill_r0", 8'h42, 2'd1);
    pop_expect("fill_r1", 8'h99, 2'd3);
    check("fill_rsp_empty", {31'd0, rsp_valid}, 32'd0);

    // Response FIFO full: only four reads may be outstanding in it.
    launch_q.delete();
    base      = launch_cnt;
    model_lat = 2;
    for (int i = 0; i < 6; i++) push(OP_READ, NS'(i), 16'h0010 + 16'(i));
    repeat (40) @(negedge clk);
    check("bp_launches_4", launch_cnt - base, 32'd4);
    check("bp_busy", {31'd0, busy}, 32'd1);
    pop_expect("bp_r0", 8'h10, 2'd0);
    repeat (20) @(negedge clk);
    check("bp_launches_5", launch_cnt - base, 32'd5);
    for (int i = 1; i < 6; i++) pop_expect("bp_rn", 8'h10 + 8'(i), NS'(i));
    wait_idle("bp");
    check("bp_launches_6", launch_cnt - base, 32'd6);
    check("bp_rsp_empty", {31'd0, rsp_valid}, 32'd0);

`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
    // LAUNCH cycle plus 16 silent WAIT_EOT cycles: flag visible 17 negedges after the start pulse.
    model_en = 1'b0;
    launch_q.delete();
    push(OP_READ, 2'd1, 16'h0077);
    cnt = 0;
    while (!start_transaction && cnt < 20) begin @(negedge clk); cnt++; end
    cnt = 0;
    while (!timeout_error && cnt < 100) begin @(negedge clk); cnt++; end
    check("to_cycles", cnt, 32'd17);
    wait_idle("to");
    check("to_no_rsp", {31'd0, rsp_valid}, 32'd0);
    model_en = 1'b1;
    launch_q.delete();
    push(OP_WRITE, 2'd3, 16'h4444);
    wait_idle("to_next");
    expect_launch("to_next_launch", {OP_WRITE, 2'd3, 16'h4444});
    check("to_sticky", {31'd0, timeout_error}, 32'd1);
`else
    check("no_timeout_flag", {31'd0, timeout_error}, 32'd0);
`endif

    // Reset while a read waits for its end of transaction, with more commands queued.
    model_en = 1'b0;
    push(OP_READ,  2'd2, 16'h0005);
    push(OP_WRITE, 2'd1, 16'h5555);
    push(OP_WRITE, 2'd3, 16'h6666);
    repeat (3) @(negedge clk);
    check("mid_slave", {30'd0, slave}, 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_start", {31'd0, start_transaction}, 32'd0);
    check("mid_rst_slave", {30'd0, slave}, 32'd0);
    check("mid_rst_operation", {31'd0, operation}, 32'd0);
    check("mid_rst_outgoing_data", {16'd0, outgoing_data}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_timeout_error", {31'd0, timeout_error}, 32'd0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    base = launch_cnt;
    repeat (10) @(negedge clk);
    check("post_rst_no_launch", launch_cnt - base, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    model_en = 1'b1;
    launch_q.delete();
    push(OP_READ, 2'd3, 16'h00C3);
    wait_idle("post_rst");
    expect_launch("post_rst_launch", {OP_READ, 2'd3, 16'h00C3});
    pop_expect("post_rst", 8'hC3, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
